// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and scan-code key-state tracker.
// Optional caps-lock modifier handling via PS2_CAPSLOCK_EN.
module ps2_key_decoder #(
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] my_data,
   output logic       pre,
   output logic       up,
   output logic [7:0] count,
   output logic       ready,
   output logic       err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   logic [2:0]    clk_sync;
   logic [2:0]    dat_sync;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic [TW-1:0] to_cnt;
   logic          fall;
   logic          frame_done;
   logic          frame_ok;
   logic          frame_bad;
   logic [7:0]    code;

   assign fall       = clk_sync[2] & ~clk_sync[1];
   assign frame_done = fall && (bit_cnt == 4'd10);
   assign code       = shreg[8:1];
   // shreg[0] is the start bit, shreg[9] parity, stop bit is the live sample
   assign frame_ok   = frame_done && !shreg[0] && dat_sync[1] && (^shreg[9:1]);
   assign frame_bad  = frame_done && !frame_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync <= 3'b111;
         dat_sync <= 3'b111;
         bit_cnt  <= 4'd0;
         shreg    <= 10'd0;
         to_cnt   <= '0;
      end else begin
         clk_sync <= {clk_sync[1:0], ps2_clk};
         dat_sync <= {dat_sync[1:0], ps2_data};
         if (fall) begin
            to_cnt <= '0;
            if (bit_cnt == 4'd10) begin
               bit_cnt <= 4'd0;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               shreg   <= {dat_sync[1], shreg[9:1]};
            end
         end else if (bit_cnt != 4'd0) begin
            if (to_cnt == TW'(TIMEOUT - 1)) begin
               bit_cnt <= 4'd0;
               to_cnt  <= '0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end
      end
   end

   state_t     state;
   state_t     nxt;
   logic       key_ev;
   logic       key_brk;
   logic       key_ext;
   logic       is_sl;
   logic       is_sr;
   logic       is_caps;
   logic       is_fake;
   logic       is_mod;
   logic       shift_l;
   logic       shift_r;
   logic       caps;
   logic [7:0] held;

   always_comb begin
      nxt     = state;
      key_ev  = 1'b0;
      key_brk = 1'b0;
      key_ext = 1'b0;
      unique case (state)
         IDLE: begin
            if (code == 8'hE0)      nxt = EXT;
            else if (code == 8'hF0) nxt = BRK;
            else                    key_ev = 1'b1;
         end
         EXT: begin
            if (code == 8'hF0) begin
               nxt = EXT_BRK;
            end else begin
               key_ev  = 1'b1;
               key_ext = 1'b1;
               nxt     = IDLE;
            end
         end
         BRK: begin
            key_ev  = 1'b1;
            key_brk = 1'b1;
            nxt     = IDLE;
         end
         EXT_BRK: begin
            key_ev  = 1'b1;
            key_brk = 1'b1;
            key_ext = 1'b1;
            nxt     = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   assign is_fake = key_ext && (code == 8'h12);
   assign is_sl   = !key_ext && (code == 8'h12);
   assign is_sr   = !key_ext && (code == 8'h59);
`ifdef PS2_CAPSLOCK_EN
   assign is_caps = !key_ext && (code == 8'h58);
`else
   assign is_caps = 1'b0;
`endif
   assign is_mod  = is_fake | is_sl | is_sr | is_caps;
   assign up      = (shift_l | shift_r) ^ caps;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         my_data <= 8'd0;
         pre     <= 1'b0;
         count   <= 8'd0;
         held    <= 8'd0;
         shift_l <= 1'b0;
         shift_r <= 1'b0;
         ready   <= 1'b0;
         err     <= 1'b0;
      end else begin
         ready <= frame_ok;
         err   <= frame_bad;
         if (frame_ok) begin
            state <= nxt;
            if (!key_ev) begin
               my_data <= code;
            end else if (is_sl) begin
               shift_l <= !key_brk;
            end else if (is_sr) begin
               shift_r <= !key_brk;
            end else if (!is_mod) begin
               my_data <= code;
               if (key_brk) begin
                  if (code == held) pre <= 1'b0;
               end else if (!(pre && (held == code))) begin
                  count <= count + 8'd1;
                  held  <= code;
                  pre   <= 1'b1;
               end
            end
         end
      end
   end

`ifdef PS2_CAPSLOCK_EN
   logic caps_down;

   // caps_down suppresses toggling on typematic repeats of 0x58
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         caps      <= 1'b0;
         caps_down <= 1'b0;
      end else if (frame_ok && is_caps) begin
         if (key_brk) begin
            caps_down <= 1'b0;
         end else begin
            caps_down <= 1'b1;
            if (!caps_down) caps <= ~caps;
         end
      end
   end
`else
   assign caps = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized bench for ps2_key_decoder against a key-state reference model.
module tb_ps2_key_decoder;

   localparam int TO  = 100;
   localparam int HP  = 4;
   localparam int GAP = 16;
`ifdef PS2_CAPSLOCK_EN
   localparam bit CAPS_EN = 1'b1;
`else
   localparam bit CAPS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] my_data;
   logic       pre;
   logic       up;
   logic [7:0] count;
   logic       ready;
   logic       err;

   ps2_key_decoder #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .my_data(my_data), .pre(pre), .up(up), .count(count),
      .ready(ready), .err(err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int rdy_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   logic [7:0] rdy_data = 8'h00;
   int d_ready;
   int d_err;

   always @(negedge clk) begin
      if (!reset) begin
         if (ready) begin
            rdy_cnt  <= rdy_cnt + 1;
            rdy_data <= my_data;
         end
         if (err) err_cnt <= err_cnt + 1;
         if (ready && err) both_cnt <= both_cnt + 1;
      end
   end

   // reference key-state model
   logic [7:0] m_data, m_held, m_count;
   bit m_pre, m_sl, m_sr, m_caps, m_caps_down, m_brk, m_ext;

   function automatic bit m_up();
      return (m_sl | m_sr) ^ m_caps;
   endfunction

   task automatic model_reset();
      m_data = 0; m_held = 0; m_count = 0; m_pre = 0;
      m_sl = 0; m_sr = 0; m_caps = 0; m_caps_down = 0;
      m_brk = 0; m_ext = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      bit is_brk, is_ext;
      if (!m_brk && !m_ext && b == 8'hE0) begin
         m_ext = 1; m_data = b;
      end else if (!m_brk && b == 8'hF0) begin
         m_brk = 1; m_data = b;
      end else begin
         is_brk = m_brk; is_ext = m_ext;
         m_brk = 0; m_ext = 0;
         if (is_ext && b == 8'h12) begin
         end else if (!is_ext && b == 8'h12) begin
            m_sl = !is_brk;
         end else if (!is_ext && b == 8'h59) begin
            m_sr = !is_brk;
         end else if (CAPS_EN && !is_ext && b == 8'h58) begin
            if (is_brk) m_caps_down = 0;
            else begin
               if (!m_caps_down) m_caps = !m_caps;
               m_caps_down = 1;
            end
         end else begin
            m_data = b;
            if (is_brk) begin
               if (b == m_held) m_pre = 0;
            end else if (!(m_pre && m_held == b)) begin
               m_count = m_count + 8'd1;
               m_held = b;
               m_pre = 1;
            end
         end
      end
   endtask

   task automatic send_bits(input logic [10:0] bits, input int nb);
      for (int i = 0; i < nb; i++) begin
         @(negedge clk) ps2_data = bits[i];
         repeat (HP) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HP) @(negedge clk);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad);
      int r0, e0;
      logic p;
      r0 = rdy_cnt; e0 = err_cnt;
      p = (~^b) ^ bad;
      send_bits({1'b1, p, b, 1'b0}, 11);
      repeat (GAP) @(negedge clk);
      ps2_data = 1'b1;
      d_ready = rdy_cnt - r0;
      d_err = err_cnt - e0;
      if (!bad) model_byte(b);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      model_reset();
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_vec += 6;
      if (my_data !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h want 00", my_data); end
      if (pre !== 1'b0) begin n_bad++; $display("FAIL rst_pre got %b want 0", pre); end
      if (up !== 1'b0) begin n_bad++; $display("FAIL rst_up got %b want 0", up); end
      if (count !== 8'h00) begin n_bad++; $display("FAIL rst_count got %h want 00", count); end
      if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", ready); end
      if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      model_reset();
   endtask

   task automatic test_basic();
      send_frame(8'h1C, 0);
      n_vec += 7;
      if (d_ready !== 1) begin n_bad++; $display("FAIL basic_ready got %0d want 1", d_ready); end
      if (d_err !== 0) begin n_bad++; $display("FAIL basic_err got %0d want 0", d_err); end
      if (rdy_data !== 8'h1C) begin n_bad++; $display("FAIL basic_rdy_data got %h want 1c", rdy_data); end
      if (my_data !== 8'h1C) begin n_bad++; $display("FAIL basic_data got %h want 1c", my_data); end
      if (pre !== 1'b1) begin n_bad++; $display("FAIL basic_pre got %b want 1", pre); end
      if (count !== 8'd1) begin n_bad++; $display("FAIL basic_count got %0d want 1", count); end
      if (up !== 1'b0) begin n_bad++; $display("FAIL basic_up got %b want 0", up); end
   endtask

   task automatic test_typematic();
      for (int i = 0; i < 3; i++) begin
         send_frame(8'h1C, 0);
         n_vec++;
         if (count !== 8'd1) begin n_bad++; $display("FAIL rep_count[%0d] got %0d want 1", i, count); end
      end
      send_frame(8'hF0, 0);
      n_vec += 3;
      if (my_data !== 8'hF0) begin n_bad++; $display("FAIL rep_f0_data got %h want f0", my_data); end
      if (pre !== 1'b1) begin n_bad++; $display("FAIL rep_f0_pre got %b want 1", pre); end
      if (count !== 8'd1) begin n_bad++; $display("FAIL rep_f0_count got %0d want 1", count); end
      send_frame(8'h1C, 0);
      n_vec += 3;
      if (my_data !== 8'h1C) begin n_bad++; $display("FAIL rep_brk_data got %h want 1c", my_data); end
      if (pre !== 1'b0) begin n_bad++; $display("FAIL rep_brk_pre got %b want 0", pre); end
      if (count !== 8'd1) begin n_bad++; $display("FAIL rep_brk_count got %0d want 1", count); end
   endtask

   task automatic test_shift();
      do_reset();
      send_frame(8'h12, 0);
      n_vec += 3;
      if (up !== 1'b1) begin n_bad++; $display("FAIL sh_up got %b want 1", up); end
      if (my_data !== 8'h00) begin n_bad++; $display("FAIL sh_data got %h want 00", my_data); end
      if (d_ready !== 1) begin n_bad++; $display("FAIL sh_ready got %0d want 1", d_ready); end
      send_frame(8'h1C, 0);
      n_vec += 3;
      if (up !== 1'b1) begin n_bad++; $display("FAIL sh_key_up got %b want 1", up); end
      if (count !== 8'd1) begin n_bad++; $display("FAIL sh_key_count got %0d want 1", count); end
      if (my_data !== 8'h1C) begin n_bad++; $display("FAIL sh_key_data got %h want 1c", my_data); end
      send_frame(8'hF0, 0);
      send_frame(8'h12, 0);
      n_vec += 3;
      if (up !== 1'b0) begin n_bad++; $display("FAIL sh_rel_up got %b want 0", up); end
      if (pre !== 1'b1) begin n_bad++; $display("FAIL sh_rel_pre got %b want 1", pre); end
      if (my_data !== 8'hF0) begin n_bad++; $display("FAIL sh_rel_data got %h want f0", my_data); end
      send_frame(8'hE0, 0);
      send_frame(8'h12, 0);
      n_vec += 2;
      if (up !== 1'b0) begin n_bad++; $display("FAIL fake_up got %b want 0", up); end
      if (my_data !== 8'hE0) begin n_bad++; $display("FAIL fake_data got %h want e0", my_data); end
   endtask

   task automatic test_err_timeout();
      do_reset();
      send_frame(8'h1C, 0);
      send_frame(8'h1C, 1);
      n_vec += 5;
      if (d_err !== 1) begin n_bad++; $display("FAIL par_err got %0d want 1", d_err); end
      if (d_ready !== 0) begin n_bad++; $display("FAIL par_ready got %0d want 0", d_ready); end
      if (my_data !== 8'h1C) begin n_bad++; $display("FAIL par_data got %h want 1c", my_data); end
      if (count !== 8'd1) begin n_bad++; $display("FAIL par_count got %0d want 1", count); end
      if (pre !== 1'b1) begin n_bad++; $display("FAIL par_pre got %b want 1", pre); end
      send_bits(11'b110_0101_0100, 4);
      repeat (TO + 20) @(negedge clk);
      send_frame(8'h32, 0);
      n_vec += 4;
      if (d_ready !== 1) begin n_bad++; $display("FAIL to_ready got %0d want 1", d_ready); end
      if (d_err !== 0) begin n_bad++; $display("FAIL to_err got %0d want 0", d_err); end
      if (my_data !== 8'h32) begin n_bad++; $display("FAIL to_data got %h want 32", my_data); end
      if (count !== 8'd2) begin n_bad++; $display("FAIL to_count got %0d want 2", count); end
   endtask

   task automatic test_caps();
      do_reset();
      if (CAPS_EN) begin
         send_frame(8'h58, 0);
         n_vec++;
         if (up !== 1'b1) begin n_bad++; $display("FAIL caps_on got %b want 1", up); end
         send_frame(8'h58, 0);
         send_frame(8'hF0, 0);
         send_frame(8'h58, 0);
         n_vec += 2;
         if (up !== 1'b1) begin n_bad++; $display("FAIL caps_hold got %b want 1", up); end
         if (count !== 8'd0) begin n_bad++; $display("FAIL caps_count got %0d want 0", count); end
         send_frame(8'h58, 0);
         send_frame(8'hF0, 0);
         send_frame(8'h58, 0);
         n_vec++;
         if (up !== 1'b0) begin n_bad++; $display("FAIL caps_off got %b want 0", up); end
      end else begin
         send_frame(8'h58, 0);
         n_vec += 3;
         if (my_data !== 8'h58) begin n_bad++; $display("FAIL nocaps_data got %h want 58", my_data); end
         if (count !== 8'd1) begin n_bad++; $display("FAIL nocaps_count got %0d want 1", count); end
         if (up !== 1'b0) begin n_bad++; $display("FAIL nocaps_up got %b want 0", up); end
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit bad;
      do_reset();
      for (int i = 0; i < 100; i++) begin
         case ($urandom_range(0, 9))
            5: b = 8'hF0;
            6: b = 8'hE0;
            7: b = 8'h12;
            8: b = 8'h59;
            9: b = 8'h58;
            default: b = 8'($urandom_range(1, 8));
         endcase
         bad = ($urandom_range(0, 7) == 0);
         send_frame(b, bad);
         n_vec += 6;
         if (d_ready !== (bad ? 0 : 1)) begin n_bad++; $display("FAIL rnd_ready[%0d] got %0d bad=%b", i, d_ready, bad); end
         if (d_err !== (bad ? 1 : 0)) begin n_bad++; $display("FAIL rnd_err[%0d] got %0d bad=%b", i, d_err, bad); end
         if (my_data !== m_data) begin n_bad++; $display("FAIL rnd_data[%0d] got %h want %h", i, my_data, m_data); end
         if (pre !== m_pre) begin n_bad++; $display("FAIL rnd_pre[%0d] got %b want %b", i, pre, m_pre); end
         if (count !== m_count) begin n_bad++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, m_count); end
         if (up !== m_up()) begin n_bad++; $display("FAIL rnd_up[%0d] got %b want %b", i, up, m_up()); end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] b;
      logic [7:0] prev;
      int r0;
      do_reset();
      prev = 8'h00;
      r0 = rdy_cnt;
      for (int i = 0; i < 256; i++) begin
         do b = 8'($urandom_range(1, 127));
         while (b == prev || b == 8'h12 || b == 8'h59 || b == 8'h58);
         prev = b;
         send_frame(b, 0);
      end
      n_vec += 4;
      if (rdy_cnt - r0 !== 256) begin n_bad++; $display("FAIL wrap_ready got %0d want 256", rdy_cnt - r0); end
      if (count !== 8'd0) begin n_bad++; $display("FAIL wrap_count got %0d want 0", count); end
      if (count !== m_count) begin n_bad++; $display("FAIL wrap_model got %0d want %0d", count, m_count); end
      if (my_data !== prev) begin n_bad++; $display("FAIL wrap_data got %h want %h", my_data, prev); end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      send_frame(8'h1C, 0);
      send_bits(11'b101_1010_1010, 5);
      @(negedge clk) reset = 1'b1;
      repeat (2) @(negedge clk);
      n_vec += 3;
      if (my_data !== 8'h00) begin n_bad++; $display("FAIL mid_data got %h want 00", my_data); end
      if (count !== 8'd0) begin n_bad++; $display("FAIL mid_count got %0d want 0", count); end
      if (pre !== 1'b0) begin n_bad++; $display("FAIL mid_pre got %b want 0", pre); end
      reset = 1'b0;
      ps2_data = 1'b1;
      model_reset();
      repeat (10) @(negedge clk);
      send_frame(8'h2A, 0);
      n_vec += 5;
      if (d_ready !== 1) begin n_bad++; $display("FAIL mid_ready got %0d want 1", d_ready); end
      if (d_err !== 0) begin n_bad++; $display("FAIL mid_err got %0d want 0", d_err); end
      if (my_data !== 8'h2A) begin n_bad++; $display("FAIL mid_next_data got %h want 2a", my_data); end
      if (count !== 8'd1) begin n_bad++; $display("FAIL mid_next_count got %0d want 1", count); end
      if (pre !== 1'b1) begin n_bad++; $display("FAIL mid_next_pre got %b want 1", pre); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_typematic();
      test_shift();
      test_err_timeout();
      test_caps();
      test_random();
      test_wrap();
      test_reset_midframe();
      n_vec++;
      if (both_cnt !== 0) begin n_bad++; $display("FAIL ready_err_overlap got %0d want 0", both_cnt); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
